ctrl: RTL and testbench

CTRL -- requirements
Module: ctrl

---
 rtl/ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl.sv
// RV32I control decoder: splits an instruction into register fields, immediate and datapath controls, registered.
// Optional macro CTRL_ILLEGAL_EN enables the registered `illegal` flag; otherwise it is tied low.
module ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        jalr,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [3:0]  alu_op,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [3:0]      f3_op;

  logic [XLEN-1:0] imm_nxt;
  logic            reg_write_nxt, mem_read_nxt, mem_write_nxt;
  logic            branch_nxt, jump_nxt, jalr_nxt, alu_src_b_nxt;
  logic [1:0]      alu_src_a_nxt, wb_sel_nxt;
  logic [3:0]      alu_op_nxt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];

  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Base ALU operation implied by funct3; the inst[30] variants are applied per opcode.
  always_comb begin
    f3_op = ALU_ADD;
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  // Opcode decode; anything unrecognised stays at the all-zero NOP defaults.
  always_comb begin
    imm_nxt       = '0;
    reg_write_nxt = 1'b0;
    mem_read_nxt  = 1'b0;
    mem_write_nxt = 1'b0;
    branch_nxt    = 1'b0;
    jump_nxt      = 1'b0;
    jalr_nxt      = 1'b0;
    alu_src_a_nxt = SRC_A_RS1;
    alu_src_b_nxt = 1'b0;
    wb_sel_nxt    = WB_ALU;
    alu_op_nxt    = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        reg_write_nxt = 1'b1; alu_src_a_nxt = SRC_A_ZERO; alu_src_b_nxt = 1'b1; imm_nxt = u_imm;
      end
      OPC_AUIPC: begin
        reg_write_nxt = 1'b1; alu_src_a_nxt = SRC_A_PC; alu_src_b_nxt = 1'b1; imm_nxt = u_imm;
      end
      OPC_JAL: begin
        jump_nxt = 1'b1; reg_write_nxt = 1'b1; alu_src_a_nxt = SRC_A_PC; alu_src_b_nxt = 1'b1;
        wb_sel_nxt = WB_PC4; imm_nxt = j_imm;
      end
      OPC_JALR: begin
        jalr_nxt = 1'b1; reg_write_nxt = 1'b1; alu_src_b_nxt = 1'b1;
        wb_sel_nxt = WB_PC4; imm_nxt = i_imm;
      end
      OPC_BRANCH: begin
        branch_nxt = 1'b1; alu_src_a_nxt = SRC_A_PC; alu_src_b_nxt = 1'b1; imm_nxt = b_imm;
      end
      OPC_LOAD: begin
        mem_read_nxt = 1'b1; reg_write_nxt = 1'b1; alu_src_b_nxt = 1'b1;
        wb_sel_nxt = WB_MEM; imm_nxt = i_imm;
      end
      OPC_STORE: begin
        mem_write_nxt = 1'b1; alu_src_b_nxt = 1'b1; imm_nxt = s_imm;
      end
      OPC_OPIMM: begin
        reg_write_nxt = 1'b1; alu_src_b_nxt = 1'b1; imm_nxt = i_imm; alu_op_nxt = f3_op;
        if (f3 == 3'b101 && inst[30]) alu_op_nxt = ALU_SRA;
      end
      OPC_OP: begin
        reg_write_nxt = 1'b1; alu_op_nxt = f3_op;
        if (inst[30] && f3 == 3'b000) alu_op_nxt = ALU_SUB;
        if (inst[30] && f3 == 3'b101) alu_op_nxt = ALU_SRA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      funct3    <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      jump      <= 1'b0;
      jalr      <= 1'b0;
      alu_src_a <= '0;
      alu_src_b <= 1'b0;
      wb_sel    <= '0;
      alu_op    <= '0;
    end else begin
      rd        <= inst[11:7];
      rs1       <= inst[19:15];
      rs2       <= inst[24:20];
      funct3    <= f3;
      imm       <= imm_nxt;
      reg_write <= reg_write_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      branch    <= branch_nxt;
      jump      <= jump_nxt;
      jalr      <= jalr_nxt;
      alu_src_a <= alu_src_a_nxt;
      alu_src_b <= alu_src_b_nxt;
      wb_sel    <= wb_sel_nxt;
      alu_op    <= alu_op_nxt;
    end
  end

`ifdef CTRL_ILLEGAL_EN
  logic illegal_nxt;

  // Every supported opcode ends in 2'b11, so a bad low pair also lands in default.
  always_comb begin
    illegal_nxt = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: illegal_nxt = (inst[1:0] != 2'b11);
      default: illegal_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= illegal_nxt;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: directed vector table, reset sequences and randomized decode vs a reference model.
module tb_ctrl;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic        illegal;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    out_t        exp;
  } vec_t;

`ifdef CTRL_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        reg_write, mem_read, mem_write, branch, jump, jalr, alu_src_b, illegal;
  logic [1:0]  alu_src_a, wb_sel;
  logic [3:0]  alu_op;
  out_t        got;

  int cmp_n = 0;
  int fail_n = 0;

  ctrl dut (
    .clk(clk), .rst(rst), .inst(inst),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .jalr(jalr),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .alu_op(alu_op), .illegal(illegal)
  );

  assign got = {rd, rs1, rs2, funct3, imm, reg_write, mem_read, mem_write, branch,
                jump, jalr, alu_src_a, alu_src_b, wb_sel, alu_op, illegal};

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [4:0] f_rd, input logic [4:0] f_rs1,
                              input logic [4:0] f_rs2, input logic [2:0] f_f3,
                              input logic [31:0] f_imm, input logic [5:0] en,
                              input logic [1:0] a, input logic b, input logic [1:0] wb,
                              input logic [3:0] op, input logic ill);
    out_t o;
    o = {f_rd, f_rs1, f_rs2, f_f3, f_imm, en, a, b, wb, op, ill};
    return o;
  endfunction

  // Reference decode from the ISA rules; immediates are rebuilt arithmetically from signed fields.
  function automatic out_t model(input logic [31:0] i);
    out_t o;
    int   sx, sgn, v;
    int   op_of_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    bit   known;
    o = '0;
    sx = int'($signed(i));
    sgn = (sx < 0) ? -1 : 0;
    o.rd = i[11:7]; o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.funct3 = i[14:12];
    known = 1'b1;
    case (i[6:0])
      7'h37: begin o.reg_write = 1; o.alu_src_a = 2; o.alu_src_b = 1; o.imm = i & 32'hFFFF_F000; end
      7'h17: begin o.reg_write = 1; o.alu_src_a = 1; o.alu_src_b = 1; o.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        o.jump = 1; o.reg_write = 1; o.alu_src_a = 1; o.alu_src_b = 1; o.wb_sel = 2;
        v = sgn * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        o.imm = 32'(v);
      end
      7'h67: begin o.jalr = 1; o.reg_write = 1; o.alu_src_b = 1; o.wb_sel = 2; o.imm = 32'(sx >>> 20); end
      7'h63: begin
        o.branch = 1; o.alu_src_a = 1; o.alu_src_b = 1;
        v = sgn * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        o.imm = 32'(v);
      end
      7'h03: begin o.mem_read = 1; o.reg_write = 1; o.alu_src_b = 1; o.wb_sel = 1; o.imm = 32'(sx >>> 20); end
      7'h23: begin
        o.mem_write = 1; o.alu_src_b = 1;
        v = (sx >>> 25) * 32 + int'(i[11:7]);
        o.imm = 32'(v);
      end
      7'h13: begin
        o.reg_write = 1; o.alu_src_b = 1; o.imm = 32'(sx >>> 20);
        o.alu_op = 4'(op_of_f3[i[14:12]]);
        if (i[14:12] == 5 && i[30]) o.alu_op = 7;
      end
      7'h33: begin
        o.reg_write = 1;
        o.alu_op = 4'(op_of_f3[i[14:12]]);
        if (i[30] && i[14:12] == 0) o.alu_op = 1;
        if (i[30] && i[14:12] == 5) o.alu_op = 7;
      end
      default: known = 1'b0;
    endcase
    o.illegal = ILL_EN && !known;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    cmp_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s inst=%h got=%h exp=%h (rd=%0d imm=%h rw=%b op=%0d ill=%b)",
               name, inst, got, exp, rd, imm, reg_write, alu_op, illegal);
    end
  endtask

  task automatic step(input logic [31:0] i);
    @(negedge clk);
    inst = i;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [11];
  logic [6:0] opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    // en = {reg_write, mem_read, mem_write, branch, jump, jalr}
    vecs[0]  = '{32'hFFFFF0B7, mk(1, 31, 31, 7, 32'hFFFFF000, 6'b100000, 2, 1, 0, 0, 0)};
    vecs[1]  = '{32'hFFFFF297, mk(5, 31, 31, 7, 32'hFFFFF000, 6'b100000, 1, 1, 0, 0, 0)};
    vecs[2]  = '{32'h7FF0736F, mk(6, 0, 31, 7, 32'h00007FFE, 6'b100010, 1, 1, 2, 0, 0)};
    vecs[3]  = '{32'h00030083, mk(1, 6, 0, 0, 32'h0, 6'b110000, 0, 1, 1, 0, 0)};
    vecs[4]  = '{32'h0000007F, mk(0, 0, 0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, ILL_EN)};
    vecs[5]  = '{32'h402081B3, mk(3, 1, 2, 0, 32'h0, 6'b100000, 0, 0, 0, 1, 0)};
    vecs[6]  = '{32'h40335293, mk(5, 6, 3, 5, 32'h00000403, 6'b100000, 0, 1, 0, 7, 0)};
    vecs[7]  = '{32'hFE20AE23, mk(28, 1, 2, 2, 32'hFFFFFFFC, 6'b001000, 0, 1, 0, 0, 0)};
    vecs[8]  = '{32'h80000063, mk(0, 0, 0, 0, 32'hFFFFF000, 6'b000100, 1, 1, 0, 0, 0)};
    vecs[9]  = '{32'h00000013, mk(0, 0, 0, 0, 32'h0, 6'b100000, 0, 1, 0, 0, 0)};
    vecs[10] = '{32'h00030080, mk(1, 6, 0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, ILL_EN)};

    // Async reset before any clock edge
    inst = 32'hFFFFF0B7;
    #2 rst = 1'b1;
    #1 check("reset_initial", '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_after_reset", vecs[0].exp);

    foreach (vecs[k]) begin
      step(vecs[k].inst);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Reset asserted mid-cycle clears outputs without an edge
    step(32'h7FF0736F);
    @(negedge clk); #2;
    rst = 1'b1;
    #1 check("reset_async", '0);
    inst = 32'hFFFFF297;
    @(posedge clk); #1;
    check("reset_hold_edge", '0);
    @(negedge clk);
    rst = 1'b0;
    inst = 32'h00030083;
    #1 check("reset_release_no_edge", '0);
    @(posedge clk); #1;
    check("reset_release_first", model(32'h00030083));

    // Randomized decode against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] r;
      int unsigned sel;
      r = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 9) r[6:0] = opcs[sel];
      step(r);
      check("random", model(r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
